// File: rtl/led_pwm_fader.sv
// led_pwm_fader: LED PWM driver with breathe/steady brightness capped at led_full.
// Duty is latched only at the PWM period boundary, so the output never glitches.
module led_pwm_fader #(
    parameter int FADE_DIV   = 256,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 64
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       enable,
    input  logic       breathe,
    input  logic [7:0] led_full,
    output logic       led,
    output logic [7:0] level,
    output logic [2:0] state
);
    localparam int PW = $clog2(FADE_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4,
        STEADY  = 3'd5
    } state_t;

    state_t        st;
    logic [7:0]    duty, pwm_cnt, stepped;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold_cnt;
    logic [8:0]    up;
    logic          en_q, breathing, tick, act, hold_done;

    assign breathing = st inside {RISE, HOLD_HI, FALL, HOLD_LO};
    assign tick      = breathing && presc == PW'(FADE_DIV - 1);
    // a tick that coincides with leaving breathe mode must not step the level
    assign act       = tick && breathe;
    assign hold_done = hold_cnt == HW'(HOLD_TICKS - 1);
    assign up        = {1'b0, level} + 9'(STEP);
    assign stepped   = (st == RISE && act) ? ((up > {1'b0, led_full}) ? led_full : up[7:0]) :
                       (st == FALL && act) ? ((level > 8'(STEP)) ? level - 8'(STEP) : 8'd0) :
                       level;
    assign led       = en_q && pwm_cnt < duty;
    assign state     = st;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            st       <= IDLE;
            level    <= 8'd0;
            duty     <= 8'd0;
            pwm_cnt  <= 8'd0;
            presc    <= '0;
            hold_cnt <= '0;
            en_q     <= 1'b0;
        end else if (!enable) begin
            st       <= IDLE;
            level    <= 8'd0;
            duty     <= 8'd0;
            pwm_cnt  <= 8'd0;
            presc    <= '0;
            hold_cnt <= '0;
            en_q     <= 1'b0;
        end else begin
            en_q    <= 1'b1;
            pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
            if (pwm_cnt == 8'd254)
                duty <= level;
            presc <= (breathing && !tick) ? presc + 1'b1 : '0;
            level <= (st == STEADY) ? led_full : (level > led_full) ? led_full : stepped;
            if (breathing && !breathe)
                st <= STEADY;
            else begin
                case (st)
                    IDLE:   st <= breathe ? RISE : STEADY;
                    STEADY: if (breathe) st <= FALL;
                    RISE: begin
                        if (tick && level == led_full) begin
                            st       <= HOLD_HI;
                            hold_cnt <= '0;
                        end
                    end
                    HOLD_HI: begin
                        if (tick) begin
                            if (hold_done) st <= FALL;
                            else hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    FALL: begin
                        if (tick && level == 8'd0) begin
                            st       <= HOLD_LO;
                            hold_cnt <= '0;
                        end
                    end
                    HOLD_LO: begin
                        if (tick) begin
                            if (hold_done) st <= RISE;
                            else hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed scenarios plus randomized run against a behavioural model.
module tb_led_pwm_fader;
    localparam int FD = 4, ST = 1, HT = 2;

    logic       clk = 1'b0, RESET = 1'b0, enable = 1'b0, breathe = 1'b0;
    logic [7:0] led_full = 8'd0;
    logic       led;
    logic [7:0] level;
    logic [2:0] state;

    int total = 0, bad = 0;

    led_pwm_fader #(.FADE_DIV(FD), .STEP(ST), .HOLD_TICKS(HT)) dut (
        .clk(clk), .RESET(RESET), .enable(enable), .breathe(breathe),
        .led_full(led_full), .led(led), .level(level), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase is position in the 255-clock period, div counts clocks to the next fade tick
    int m_state = 0, m_level = 0, m_duty = 0, m_phase = 0, m_div = 0, m_hold = 0;
    bit m_en = 0;
    int lv, s, full;
    bit brth, tk;

    function automatic int imin(int a, int b); return a < b ? a : b; endfunction
    function automatic int imax(int a, int b); return a > b ? a : b; endfunction
    function automatic bit m_led(); return m_en && m_phase < m_duty; endfunction

    always @(posedge clk or negedge RESET) begin
        if (!RESET || !enable) begin
            m_state = 0; m_level = 0; m_duty = 0; m_phase = 0; m_div = 0; m_hold = 0; m_en = 0;
        end else begin
            lv = m_level; s = m_state; full = int'(led_full);
            brth = s >= 1 && s <= 4;
            tk = brth && m_div == FD - 1;
            m_en = 1;
            if (m_phase == 254) m_duty = lv;
            m_phase = (m_phase + 1) % 255;
            m_div = (brth && !tk) ? m_div + 1 : 0;
            if (brth && !breathe) begin
                m_state = 5;
                m_level = imin(lv, full);
            end else begin
                case (s)
                    0: m_state = breathe ? 1 : 5;
                    5: begin m_level = full; if (breathe) m_state = 3; end
                    1: begin
                        m_level = tk ? imin(lv + ST, full) : imin(lv, full);
                        if (tk && lv == full) begin m_state = 2; m_hold = 0; end
                    end
                    3: begin
                        m_level = tk ? imin(imax(lv - ST, 0), full) : imin(lv, full);
                        if (tk && lv == 0) begin m_state = 4; m_hold = 0; end
                    end
                    default: begin
                        m_level = imin(lv, full);
                        if (tk) begin
                            if (m_hold == HT - 1) m_state = (s == 2) ? 3 : 1;
                            else m_hold++;
                        end
                    end
                endcase
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        RESET = 1'b1; enable = 1'b1; breathe = 1'b1; led_full = 8'hFF;
        repeat (30) @(negedge clk);
        total++;
        if (level !== 8'(m_level)) begin bad++; $display("FAIL reset_prerun_level: got %0h want %0h", level, m_level); end
        #2 RESET = 1'b0;
        #1;
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL reset_led: got %0b want 0", led); end
        total++;
        if (level !== 8'd0) begin bad++; $display("FAIL reset_level: got %0h want 0", level); end
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        enable = 1'b0;
        @(negedge clk);
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL reset_release_idle: got %0d want 0", state); end
    endtask

    task automatic test_steady();
        int n, cnt;
        enable = 1'b1; breathe = 1'b0; led_full = 8'h80;
        @(negedge clk);
        total++;
        if (state !== 3'd5) begin bad++; $display("FAIL steady_state: got %0d want 5", state); end
        @(negedge clk);
        total++;
        if (level !== 8'h80) begin bad++; $display("FAIL steady_level: got %0h want 80", level); end
        repeat (300) begin
            @(negedge clk);
            total++;
            if (state !== 3'(m_state) || level !== 8'(m_level) || led !== m_led()) begin
                bad++; $display("FAIL steady_track: got s=%0d l=%0h led=%0b want s=%0d l=%0h led=%0b", state, level, led, m_state, m_level, m_led());
            end
        end
        n = 0;
        while (m_phase != 0 && n < 300) begin @(negedge clk); n++; end
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            if (i > 0) @(negedge clk);
            cnt += int'(led);
        end
        total++;
        if (cnt != 128) begin bad++; $display("FAIL steady_duty_count: got %0d want 128", cnt); end
    endtask

    task automatic test_breathe();
        logic [10:0] q[$];
        int t[$];
        logic [10:0] prev, cur;
        logic [10:0] exp_seq[11];
        exp_seq = '{ {3'd1,8'd0}, {3'd1,8'd1}, {3'd1,8'd2}, {3'd1,8'd3}, {3'd2,8'd3}, {3'd3,8'd3},
                     {3'd3,8'd2}, {3'd3,8'd1}, {3'd3,8'd0}, {3'd4,8'd0}, {3'd1,8'd0} };
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; breathe = 1'b1; led_full = 8'h03;
        prev = {3'd0, 8'd0};
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            total++;
            if (state !== 3'(m_state) || level !== 8'(m_level) || led !== m_led()) begin
                bad++; $display("FAIL breathe_track: got s=%0d l=%0h want s=%0d l=%0h", state, level, m_state, m_level);
            end
            cur = {state, level};
            if (cur !== prev) begin q.push_back(cur); t.push_back(c); end
            prev = cur;
        end
        total++;
        if (q.size() < 11) begin
            bad++; $display("FAIL breathe_seq_len: got %0d want >=11", q.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                total++;
                if (q[i] !== exp_seq[i]) begin
                    bad++; $display("FAIL breathe_seq[%0d]: got s=%0d l=%0h want s=%0d l=%0h", i, q[i][10:8], q[i][7:0], exp_seq[i][10:8], exp_seq[i][7:0]);
                end
            end
            total++;
            if (t[1] - t[0] != FD) begin bad++; $display("FAIL breathe_tick_spacing: got %0d want %0d", t[1] - t[0], FD); end
            total++;
            if (t[5] - t[4] != FD * HT) begin bad++; $display("FAIL breathe_hold_len: got %0d want %0d", t[5] - t[4], FD * HT); end
        end
    endtask

    task automatic test_clamp();
        int n;
        bit prev_led;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; breathe = 1'b1; led_full = 8'hFF;
        n = 0;
        while (state !== 3'd2 && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (n >= 2000 || level !== 8'hFF) begin bad++; $display("FAIL clamp_reach_hold_hi: got s=%0d l=%0h want s=2 l=ff", state, level); end
        led_full = 8'h10;
        @(negedge clk);
        total++;
        if (level !== 8'h10) begin bad++; $display("FAIL clamp_level: got %0h want 10", level); end
        prev_led = led;
        repeat (600) begin
            @(negedge clk);
            total++;
            if (state !== 3'(m_state) || level !== 8'(m_level) || led !== m_led()) begin
                bad++; $display("FAIL clamp_track: got s=%0d l=%0h led=%0b want s=%0d l=%0h led=%0b", state, level, led, m_state, m_level, m_led());
            end
            if (led && !prev_led) begin
                total++;
                if (m_phase != 0) begin bad++; $display("FAIL clamp_mid_period_rise: got phase %0d want 0", m_phase); end
            end
            prev_led = led;
        end
    endtask

    task automatic test_extremes();
        int cnt;
        enable = 1'b1; breathe = 1'b0; led_full = 8'hFF;
        repeat (520) @(negedge clk);
        cnt = 0;
        repeat (255) begin @(negedge clk); cnt += int'(led); end
        total++;
        if (cnt != 255) begin bad++; $display("FAIL full_on_count: got %0d want 255", cnt); end
        led_full = 8'h00;
        repeat (520) @(negedge clk);
        cnt = 0;
        repeat (255) begin @(negedge clk); cnt += int'(led); end
        total++;
        if (cnt != 0) begin bad++; $display("FAIL full_off_count: got %0d want 0", cnt); end
    endtask

    task automatic test_disable();
        int n;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; breathe = 1'b1; led_full = 8'hFF;
        n = 0;
        while (!(state === 3'd3 && level === 8'h40) && n < 4000) begin @(negedge clk); n++; end
        total++;
        if (n >= 4000) begin bad++; $display("FAIL disable_reach_fall40: got s=%0d l=%0h want s=3 l=40", state, level); end
        enable = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 3'd0 || level !== 8'd0) begin bad++; $display("FAIL disable_idle: got s=%0d l=%0h want s=0 l=0", state, level); end
        @(negedge clk);
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL disable_led: got %0b want 0", led); end
        enable = 1'b1;
        @(negedge clk);
        total++;
        if (state !== 3'd1 || level !== 8'd0) begin bad++; $display("FAIL reenable_rise: got s=%0d l=%0h want s=1 l=0", state, level); end
        repeat (FD) @(negedge clk);
        total++;
        if (level !== 8'd1) begin bad++; $display("FAIL reenable_first_step: got %0h want 1", level); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                enable   = $urandom_range(0, 9) != 0;
                breathe  = 1'($urandom_range(0, 1));
                led_full = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 RESET = 1'b0;
                #2 RESET = 1'b1;
            end
            @(negedge clk);
            total++;
            if (state !== 3'(m_state) || level !== 8'(m_level) || led !== m_led()) begin
                bad++; $display("FAIL random_track@%0d: got s=%0d l=%0h led=%0b want s=%0d l=%0h led=%0b", c, state, level, led, m_state, m_level, m_led());
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_breathe();
        test_clamp();
        test_extremes();
        test_disable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
